// File: rtl/plot_sink.sv
// plot_sink: consumer end of the pixel-plot interface.
// Requests are registered (S1), clipped against the screen, converted to a
// linear framebuffer address and queued in a small FIFO that drains into the
// framebuffer write port under a grant handshake. Input is never stalled;
// losses are reported through the overflow flag and the counters.
module plot_sink #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 3,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                plot,
  input  logic signed [8:0]   x,
  input  logic signed [8:0]   y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                clr_stats,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  input  logic                mem_grant,
  output logic                overflow,
  output logic                idle,
  output logic [15:0]         written,
  output logic [15:0]         clipped
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_W + COLOUR_W;
  // Screen limits widened by one bit so the signed compare cannot wrap.
  localparam logic signed [9:0] X_LIM = 10'(SCREEN_W);
  localparam logic signed [9:0] Y_LIM = 10'(SCREEN_H);
  localparam logic [PW:0]       FULL_COUNT = (PW+1)'(DEPTH);

  // S1 input register
  logic                r_s1_valid;
  logic                r_s1_inside;
  logic [8:0]          r_s1_x;
  logic [8:0]          r_s1_y;
  logic [COLOUR_W-1:0] r_s1_colour;

  // FIFO state
  logic [EW-1:0]       r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW:0]         r_count;

  // Statistics
  logic                r_overflow;
  logic [15:0]         r_written;
  logic [15:0]         r_clipped;

  logic signed [9:0]   w_x_ext;
  logic signed [9:0]   w_y_ext;
  logic                w_inside;
  logic                w_push_req;
  logic                w_pop;
  logic                w_full;
  logic                w_push;
  logic                w_drop;
  logic                w_clip;
  logic [ADDR_W-1:0]   w_addr;
  logic [EW-1:0]       w_head;

  assign w_x_ext  = {x[8], x};
  assign w_y_ext  = {y[8], y};
  assign w_inside = (w_x_ext >= 10'sd0) && (w_x_ext < X_LIM) &&
                    (w_y_ext >= 10'sd0) && (w_y_ext < Y_LIM);

  // Only used when inside, so both coordinates are non-negative and fit in 8 bits.
  assign w_addr = ADDR_W'(r_s1_y[7:0]) * ADDR_W'(SCREEN_W) + ADDR_W'(r_s1_x[7:0]);

  assign w_push_req = r_s1_valid && r_s1_inside;
  assign w_clip     = r_s1_valid && !r_s1_inside;
  assign w_full     = (r_count == FULL_COUNT);
  assign w_pop      = mem_we && mem_grant;
  // A pop on the same edge frees the slot the push needs.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign mem_we   = (r_count != '0);
  assign w_head   = r_mem[r_rd_ptr];
  // Gate to zero while empty so the port reads 0 out of reset.
  assign mem_addr = mem_we ? w_head[EW-1:COLOUR_W] : '0;
  assign mem_data = mem_we ? w_head[COLOUR_W-1:0]  : '0;
  assign overflow = r_overflow;
  assign written  = r_written;
  assign clipped  = r_clipped;
  assign idle     = !r_s1_valid && (r_count == '0);

  // Capture the request and its on-screen test every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_inside <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_colour <= '0;
    end else begin
      r_s1_valid  <= plot;
      r_s1_inside <= w_inside;
      r_s1_x      <= x;
      r_s1_y      <= y;
      r_s1_colour <= colour;
    end
  end

  // FIFO storage; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_addr, r_s1_colour};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Statistics: clr_stats wins over any increment on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_written  <= '0;
      r_clipped  <= '0;
    end else if (clr_stats) begin
      r_overflow <= 1'b0;
      r_written  <= '0;
      r_clipped  <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_pop && (r_written != 16'hFFFF)) r_written <= r_written + 16'd1;
      if (w_clip && (r_clipped != 16'hFFFF)) r_clipped <= r_clipped + 16'd1;
    end
  end

endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink: directed scenarios followed by random traffic, checked every
// cycle against a queue-based reference model of the pixel sink.
module tb_plot_sink;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              plot;
  logic signed [8:0] x;
  logic signed [8:0] y;
  logic [2:0]        colour;
  logic              clr_stats;
  logic              mem_we;
  logic [14:0]       mem_addr;
  logic [2:0]        mem_data;
  logic              mem_grant;
  logic              overflow;
  logic              idle;
  logic [15:0]       written;
  logic [15:0]       clipped;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit m_s1_v;
  bit m_s1_in;
  int m_s1_addr;
  int m_s1_col;
  int q_addr[$];
  int q_col[$];
  bit m_ovf;
  int m_written;
  int m_clipped;

  plot_sink dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .clr_stats(clr_stats), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_grant(mem_grant), .overflow(overflow),
    .idle(idle), .written(written), .clipped(clipped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_s1_v = 0; m_s1_in = 0; m_s1_addr = 0; m_s1_col = 0;
    q_addr.delete(); q_col.delete();
    m_ovf = 0; m_written = 0; m_clipped = 0;
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, compare.
  task automatic step(input bit p, input int xi, input int yi, input int c,
                      input bit g, input bit clr);
    bit pop;
    bit wr_inc;
    bit clip_inc;
    bit ovf_set;
    plot = p; x = 9'(xi); y = 9'(yi); colour = 3'(c);
    mem_grant = g; clr_stats = clr;
    @(posedge clk);
    #1;
    pop = (q_addr.size() != 0) && g;
    wr_inc = 0; clip_inc = 0; ovf_set = 0;
    if (pop) begin
      void'(q_addr.pop_front());
      void'(q_col.pop_front());
      wr_inc = 1;
    end
    if (m_s1_v && !m_s1_in) clip_inc = 1;
    if (m_s1_v && m_s1_in) begin
      if (q_addr.size() == DEPTH) ovf_set = 1;
      else begin
        q_addr.push_back(m_s1_addr);
        q_col.push_back(m_s1_col);
      end
    end
    if (clr) begin
      m_ovf = 0; m_written = 0; m_clipped = 0;
    end else begin
      if (ovf_set) m_ovf = 1;
      if (wr_inc && m_written < 65535) m_written++;
      if (clip_inc && m_clipped < 65535) m_clipped++;
    end
    m_s1_v    = p;
    m_s1_in   = (xi >= 0) && (xi < 160) && (yi >= 0) && (yi < 120);
    m_s1_addr = yi * 160 + xi;
    m_s1_col  = c;

    chk("mem_we", 32'(mem_we), 32'(q_addr.size() != 0));
    if (q_addr.size() != 0) begin
      chk("mem_addr", 32'(mem_addr), 32'(q_addr[0]));
      chk("mem_data", 32'(mem_data), 32'(q_col[0]));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("idle", 32'(idle), 32'(!m_s1_v && q_addr.size() == 0));
    chk("written", 32'(written), 32'(m_written));
    chk("clipped", 32'(clipped), 32'(m_clipped));
  endtask

  initial begin
    reset = 1'b1; plot = 0; x = 0; y = 0; colour = 0;
    clr_stats = 0; mem_grant = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_written", 32'(written), 32'd0);
    chk("rst_clipped", 32'(clipped), 32'd0);
    reset = 1'b0;

    // Single pixel at origin: write appears two edges after sampling
    step(1, 0, 0, 5, 1, 0);
    chk("t1_we_early", 32'(mem_we), 32'd0);
    step(0, 0, 0, 0, 1, 0);
    chk("t1_we", 32'(mem_we), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd0);
    chk("t1_data", 32'(mem_data), 32'd5);
    step(0, 0, 0, 0, 1, 0);
    chk("t1_written", 32'(written), 32'd1);
    chk("t1_idle", 32'(idle), 32'd1);

    // Far corner plus four off-screen requests
    step(1, 159, 119, 7, 1, 0);
    step(1, -1, 10, 1, 1, 0);
    chk("t2_addr", 32'(mem_addr), 32'd19199);
    chk("t2_data", 32'(mem_data), 32'd7);
    step(1, 160, 0, 1, 1, 0);
    step(1, 10, 120, 1, 1, 0);
    step(1, 5, -3, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t2_clipped", 32'(clipped), 32'd4);
    chk("t2_overflow", 32'(overflow), 32'd0);
    chk("t2_written", 32'(written), 32'd2);

    // Overfill with grant low, then drain
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(1, i, 2, i, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_head", 32'(mem_addr), 32'd320);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    chk("t3_written", 32'(written), 32'd4);
    chk("t3_idle", 32'(idle), 32'd1);

    // Full FIFO with push and pop on the same edge
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 10 + i, 3, i, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t4_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    chk("t4_written", 32'(written), 32'd5);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) step(1, 20 + i, 4, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_queued", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_we_drop", 32'(mem_we), 32'd0);
    chk("t5_written", 32'(written), 32'd0);
    chk("t5_clipped", 32'(clipped), 32'd0);
    chk("t5_overflow", 32'(overflow), 32'd0);
    chk("t5_idle", 32'(idle), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(1, 1, 1, 2, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t5_addr161", 32'(mem_addr), 32'd161);
    step(0, 0, 0, 0, 1, 0);
    chk("t5_written1", 32'(written), 32'd1);

    // clr_stats on the same edge as a retiring write
    step(1, 30, 5, 1, 0, 0);
    step(1, 31, 5, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("t6_written0", 32'(written), 32'd0);
    chk("t6_still_we", 32'(mem_we), 32'd1);
    step(0, 0, 0, 0, 1, 0);
    chk("t6_written1", 32'(written), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8),
           int'($urandom_range(0, 200)) - 20,
           int'($urandom_range(0, 160)) - 20,
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0);
    chk("final_idle", 32'(idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/plot_sink.md
# plot_sink

Consumer end of the pixel-plot interface used by the screen-clear and circle-drawing controllers. Every cycle with `plot` high, it samples a signed (x, y, colour) request and discards off-screen coordinates. On-screen requests become linear framebuffer addresses, are buffered in a small FIFO, and are drained into the framebuffer write port under a grant handshake. The drawing controllers never stall, so the block accepts one request per cycle unconditionally and reports any loss through status flags and counters.

## Interface
- `SCREEN_W`, 160, visible columns; x valid range 0..SCREEN_W-1
- `SCREEN_H`, 120, visible rows; y valid range 0..SCREEN_H-1
- `COLOUR_W`, 3, colour bits per pixel
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `ADDR_W`, 15, framebuffer address width; 2^ADDR_W ≥ SCREEN_W*SCREEN_H
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `plot`  in  1  request strobe; one request per cycle it is high
- `x`  in  9  signed two's-complement column
- `y`  in  9  signed two's-complement row
- `colour`  in  COLOUR_W  pixel colour
- `clr_stats`  in  1  synchronous clear of counters and sticky flag
- `mem_we`  out  1  write request; high whenever the FIFO is non-empty
- `mem_addr`  out  ADDR_W  y*SCREEN_W + x of the FIFO head
- `mem_data`  out  COLOUR_W  colour of the FIFO head
- `mem_grant`  in  1  write accepted on an edge where `mem_we` and `mem_grant` are both high
- `overflow`  out  1  sticky; set when a valid request is dropped
- `idle`  out  1  high when the pipeline register and FIFO are both empty
- `written`  out  16  count of accepted framebuffer writes, saturating at 0xFFFF
- `clipped`  out  16  count of off-screen requests discarded, saturating at 0xFFFF

## Operation
- Stage S1 (input register): on each edge, capture `plot`, `x`, `y` and `colour`. Also capture `inside` = (0 ≤ x < SCREEN_W) && (0 ≤ y < SCREEN_H), evaluated as a signed comparison.
- Stage S2: when S1 holds a request with `inside` = 0, increment `clipped` and push nothing.
- When S1 holds a request with `inside` = 1, push {addr, colour} into the FIFO.
  - addr = (y<<7) + (y<<5) + x for the default width; the general form is y*SCREEN_W + x.
  - Truncate addr to ADDR_W bits; no overflow is possible within range.
- Pop: on an edge with `mem_we` && `mem_grant`, remove the head and increment `written`.
- Full FIFO with a push pending:
  - If a pop occurs on the same edge, the push succeeds and the count is unchanged.
  - Otherwise drop the new request (the FIFO keeps the old entries) and set `overflow`.
- Push and pop on an empty FIFO on the same edge is not possible. The head is only valid after a push, so a pushed entry cannot be popped on the edge it is written.
- FIFO read and write pointers wrap modulo DEPTH. The FIFO tracks occupancy with a count of 0..DEPTH.
- `clr_stats` zeroes `written`, `clipped` and `overflow` on the next edge. It takes priority over increments on that same edge and leaves FIFO contents untouched.
- `idle` = !S1.valid && (count == 0).

## Timing
- Reset values:
  - `mem_we` = 0, `mem_addr` = 0, `mem_data` = 0, `overflow` = 0, `idle` = 1, `written` = 0, `clipped` = 0.
  - S1 invalid, FIFO empty, pointers at 0.
- Assertion of `reset` at any point, including mid-burst, discards all queued pixels immediately. No write may be issued after `reset` rises.
- Latency: a request sampled at edge N is pushed at edge N+1, and `mem_we` is high with its address in the cycle after edge N+1. With `mem_grant` held high, the write retires at edge N+2.
- Throughput is one request per cycle in each direction. With `mem_grant` held high the FIFO never fills.
- `mem_addr` and `mem_data` are driven from FIFO storage, with no combinational path from `x`, `y` or `plot`. They must hold stable while `mem_we` is high and `mem_grant` is low.
- `clipped` increments at edge N+1 for a request sampled at edge N.

## Test plan
- Reset, then `plot` (x=0, y=0, c=5) with grant=1 → `mem_we` high 2 cycles later with addr=0, data=5; `written`=1; `idle` returns to 1.
- Plot (159,119,c=7) then (-1,10), (160,0), (10,120), (5,-3) → one write at addr=19199; `clipped`=4; `overflow`=0.
- Grant=0 and 6 consecutive valid plots with DEPTH=4 → 4 entries held; `overflow`=1. Grant=1 → the first 4 addresses drain in order; `written`=4.
- FIFO full, grant=1 and a plot on the same edge → push accepted, no overflow, order preserved.
- Assert `reset` for 1 cycle while 3 entries are queued → `mem_we` drops immediately and all counters/flags read 0. A following plot (1,1) writes addr=161.
- Pulse `clr_stats` on the same edge as a retiring write → `written`=0 afterwards, not 1; queued entries still drain.
